// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset PC and fetch FSM state type
package cpu_pkg;
    localparam int ADDR_W     = 16;
    localparam int INSTR_W    = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry prefetch queue of {pc, instr} with registered head storage
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      push,
    input  logic [ADDR_W+INSTR_W-1:0] push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic [CNT_W-1:0]          count,
    output logic [ADDR_W+INSTR_W-1:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = ADDR_W + INSTR_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC generation, credit-limited imem requests, redirect flush, prefetch queue
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int PC_INC = 2
) (
    input  logic               Clock,
    input  logic               Reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [3:0]         opcode
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + INSTR_W;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    credit_used;
    logic [ENT_W-1:0]  head;
    logic              gnt_acc, rsp_ok, push, pop, flush;

    // Queued entries reserve credit too, so a response always finds a free slot.
    assign credit_used = {1'b0, outst_q} + {1'b0, count};
    assign imem_req    = (state_q == RUN) && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign gnt_acc     = imem_req && imem_gnt;
    assign rsp_ok      = imem_rvalid && (outst_q != '0);
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign {instr_pc, instr} = head;
    assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q + CNT_W'(gnt_acc) - CNT_W'(rsp_ok);
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            flush      = 1'b1;
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            state_d    = (outst_d != '0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (gnt_acc) begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
                    end
                    if (rsp_ok) begin
                        push     = 1'b1;
                        rsp_pc_d = rsp_pc_q + ADDR_W'(PC_INC);
                    end
                end
                FLUSH: begin
                    if (outst_d == '0) begin
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .push      (push),
        .push_data ({rsp_pc_q, imem_rdata}),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit with a pipelined memory model
module tb_instr_fetch_unit;
    localparam int DEPTH = 2;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [3:0]  opcode;

    logic        gnt_en = 1'b1;
    int          lat = 1;
    int          edge_n = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] pend_addr[$];
    int          pend_due[$];
    logic [15:0] req_log[$];
    logic [15:0] got_pc[$];
    int          got_edge[$];
    logic        hold_prev = 1'b0;
    logic [15:0] prev_pc = '0;

    instr_fetch_unit dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .opcode      (opcode)
    );

    assign imem_gnt = gnt_en & imem_req;

    always #5 Clock = ~Clock;
    always @(posedge Clock) edge_n++;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[4:1] + 4'h5, a[11:0] ^ 12'hA5C};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic seq_chk(input string tag, input logic [15:0] q[$], input logic [15:0] start, input int n);
        logic [15:0] e;
        e = start;
        chk({tag, "_len"}, q.size() >= n, 1);
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk(tag, q[i], e);
            e = e + 16'd2;
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset_n  = 1'b0;
        redirect = 1'b0;
        repeat (2) step();
        req_log.delete();
        got_pc.delete();
        got_edge.delete();
        Reset_n = 1'b1;
    endtask

    // Memory model and output monitor: everything here refers to the upcoming rising edge.
    always @(negedge Clock) begin
        imem_rvalid = 1'b0;
        if (!Reset_n) begin
            pend_addr.delete();
            pend_due.delete();
            hold_prev = 1'b0;
        end else begin
            if (pend_due.size() > 0 && pend_due[0] == edge_n + 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (imem_req && imem_gnt) begin
                req_log.push_back(imem_addr);
                pend_addr.push_back(imem_addr);
                pend_due.push_back(edge_n + 1 + lat);
            end
            chk("credit", pend_due.size() <= DEPTH, 1);
            if (instr_valid) begin
                chk("instr_data", instr, mem_word(instr_pc));
                chk("opcode", opcode, instr[15:12]);
            end
            if (hold_prev) begin
                chk("hold_valid", instr_valid, 1);
                chk("hold_pc", instr_pc, prev_pc);
            end
            if (instr_valid && instr_ready) begin
                got_pc.push_back(instr_pc);
                got_edge.push_back(edge_n);
            end
            hold_prev = instr_valid && !instr_ready && !redirect;
            prev_pc   = instr_pc;
        end
    end

    initial begin
        // Reset values and boot cycle
        repeat (2) step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_addr", imem_addr, 16'h0000);
        Reset_n     = 1'b1;
        instr_ready = 1'b1;
        chk("boot_req", imem_req, 0);
        step();
        chk("run_req", imem_req, 1);
        chk("run_addr", imem_addr, 16'h0000);
        repeat (12) step();
        seq_chk("s1_req", req_log, 16'h0000, 4);
        seq_chk("s1_got", got_pc, 16'h0000, 4);

        // Consumer stall: credit limit, held head, then back-to-back drain
        instr_ready = 1'b0;
        do_reset();
        repeat (10) step();
        chk("s2_nreq", req_log.size(), 2);
        chk("s2_req_low", imem_req, 0);
        chk("s2_valid", instr_valid, 1);
        chk("s2_head_pc", instr_pc, 16'h0000);
        chk("s2_head", instr, mem_word(16'h0000));
        instr_ready = 1'b1;
        repeat (8) step();
        seq_chk("s2_drain", got_pc, 16'h0000, 4);
        if (got_edge.size() >= 2) chk("s2_b2b", got_edge[1], got_edge[0] + 1);
        else chk("s2_b2b_len", got_edge.size(), 2);

        // Redirect with two 3-cycle-latency requests in flight
        lat = 3;
        do_reset();
        repeat (3) step();
        chk("s3_nreq", req_log.size(), 2);
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        chk("s3_flush_req", imem_req, 0);
        chk("s3_flush_valid", instr_valid, 0);
        repeat (12) step();
        chk("s3_req_len", req_log.size() >= 3, 1);
        if (req_log.size() >= 3) chk("s3_req2", req_log[2], 16'h0100);
        seq_chk("s3_got", got_pc, 16'h0100, 2);

        // Redirect coincident with grant and response
        lat = 1;
        do_reset();
        repeat (2) step();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("s4_flush_req", imem_req, 0);
        chk("s4_valid", instr_valid, 0);
        repeat (10) step();
        chk("s4_req_len", req_log.size() >= 3, 1);
        if (req_log.size() >= 3) chk("s4_req2", req_log[2], 16'h0040);
        seq_chk("s4_got", got_pc, 16'h0040, 2);

        // Second redirect while flushing
        lat = 3;
        do_reset();
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        step();
        redirect_pc = 16'h0200;
        step();
        redirect = 1'b0;
        chk("s5_flush_req", imem_req, 0);
        repeat (12) step();
        for (int i = 0; i < req_log.size(); i++) chk("s5_no_0100", req_log[i] != 16'h0100, 1);
        chk("s5_req_len", req_log.size() >= 3, 1);
        if (req_log.size() >= 3) chk("s5_req2", req_log[2], 16'h0200);
        seq_chk("s5_got", got_pc, 16'h0200, 2);

        // PC wrap at the top of the address space
        lat = 1;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFC;
        step();
        redirect = 1'b0;
        repeat (14) step();
        seq_chk("s6_req", req_log, 16'hFFFC, 3);
        seq_chk("s6_got", got_pc, 16'hFFFC, 3);

        // Asynchronous reset mid-stream
        instr_ready = 1'b0;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 16'h0030;
        step();
        redirect = 1'b0;
        repeat (8) step();
        chk("s7_pre_valid", instr_valid, 1);
        chk("s7_pre_pc", instr_pc, 16'h0030);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("s7_req", imem_req, 0);
        chk("s7_valid", instr_valid, 0);
        chk("s7_instr", instr, 0);
        chk("s7_pc", instr_pc, 0);
        chk("s7_opcode", opcode, 0);
        chk("s7_addr", imem_addr, 16'h0000);
        repeat (2) step();
        req_log.delete();
        got_pc.delete();
        got_edge.delete();
        Reset_n     = 1'b1;
        instr_ready = 1'b1;
        repeat (8) step();
        seq_chk("s7_restart", req_log, 16'h0000, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
